arith_sched: RTL
================

ARITH_SCHED -- requirements
Module: arith_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 15, meaning the maximum number of cycles START may stay high without FINISH (used only with ARITH_SCHED_TIMEOUT_EN).
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-006 The block SHALL have ports req0_op / req1_op  input  2  operation code: 0 add, 1 sub, 2 mul, 3 div.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  4  operands.
REQ-008 The block SHALL have port alu_start  output  1  start level to the arithmetic datapath.
REQ-009 The block SHALL have ports alu_in1, alu_in2  output  4, and alu_sel  output  2  operands and operation select to the datapath.
REQ-010 The block SHALL have ports alu_out  input  8, alu_err  input  1, alu_finish  input  1  datapath result.
REQ-011 The block SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (winning requester), rsp_data  output  8, rsp_err  output  1.

Function
REQ-012 The block SHALL implement the states IDLE, ISSUE and RESP.
REQ-013 In IDLE, if any reqN_valid is high, the block SHALL assert reqN_ready for exactly one winner for one cycle, latch that winner's op and operands, and move to ISSUE on the next edge.
REQ-014 Arbitration SHALL be round-robin: when both requesters are valid, the one that did not win last SHALL win; after reset requester 0 SHALL have priority.
REQ-015 A request SHALL be accepted only on a cycle where reqN_valid and reqN_ready are both high; req ready SHALL be low outside IDLE.
REQ-016 In ISSUE, alu_start SHALL be held high and alu_in1/alu_in2/alu_sel SHALL be held stable at the latched values until alu_finish is sampled high.
REQ-017 On the edge where alu_finish=1, the block SHALL capture alu_out and alu_err into rsp_data and rsp_err, deassert alu_start, and move to RESP.
REQ-018 In RESP, rsp_valid SHALL be high and rsp_data, rsp_err and rsp_id SHALL be held stable until rsp_ready is high; the block SHALL then return to IDLE on that edge.
REQ-019 Minimum latency SHALL be 3 cycles from acceptance to rsp_valid, given a datapath that asserts finish one cycle after start.
REQ-020 A requester dropping valid after acceptance SHALL not affect the operation in flight.
REQ-021 alu_finish while not in ISSUE SHALL be ignored.
REQ-022 A new request SHALL be accepted on the cycle after the response handshake completes, with no bubble beyond the single IDLE cycle.

Reset
REQ-023 While rst_n is low, the block SHALL drive all outputs to 0 (alu_start, alu_in1, alu_in2, alu_sel, req ready, rsp_valid, rsp_id, rsp_data, rsp_err), set state to IDLE, and give requester 0 priority.
REQ-024 If reset is asserted mid-operation, the block SHALL abandon the operation, produce no response, and restart in IDLE.

Configuration
REQ-025 With ARITH_SCHED_TIMEOUT_EN defined, a counter SHALL run while in ISSUE; if it reaches TIMEOUT_CYC without alu_finish, the block SHALL drop alu_start and enter RESP with rsp_data=8'hFF and rsp_err=1.
REQ-026 Without ARITH_SCHED_TIMEOUT_EN, no counter SHALL exist and ISSUE SHALL wait indefinitely for alu_finish.

Verification
REQ-027 Verification SHALL drive req0 with add, a=7, b=9, and rsp_ready held high; the bench SHALL require rsp_valid with rsp_data=16, rsp_err=0, rsp_id=0, 3 cycles after acceptance.
REQ-028 Verification SHALL hold req0 and req1 valid continuously; the bench SHALL require grants that alternate 0,1,0,1 and a correct rsp_id on each response.
REQ-029 Verification SHALL drive req1 with sub, a=3, b=5; the bench SHALL require rsp_data=8'hFF and rsp_err=1.
REQ-030 Verification SHALL hold rsp_ready low for 5 cycles during a mul of 15x15; the bench SHALL require rsp_data to stay stable at 225 and no new grant.
REQ-031 Verification SHALL assert rst_n low while in ISSUE; the bench SHALL require all outputs 0 and, after release, that requester 0 wins first.
REQ-032 With ARITH_SCHED_TIMEOUT_EN defined and alu_finish tied low, the bench SHALL require rsp_err=1 and rsp_data=8'hFF after TIMEOUT_CYC cycles in ISSUE.

Source files
------------

// File: rtl/arith_sched.sv
// ---------------------------------------------------------------------------
// arith_sched
//
// Two-requester scheduler in front of a shared arithmetic datapath. A
// round-robin arbiter picks one pending request in IDLE and latches its
// opcode and operands. In ISSUE it holds alu_start and the operands steady
// until the datapath reports finish. In RESP it presents the captured result
// until the consumer takes it.
//
// Optional feature (compile-time macro ARITH_SCHED_TIMEOUT_EN):
//   A down-counter runs while in ISSUE. If TIMEOUT_CYC cycles pass without
//   alu_finish, the operation is abandoned and answered with
//   rsp_data = 8'hFF and rsp_err = 1. Without the macro no counter is built
//   and ISSUE waits for alu_finish indefinitely.
//
// Parameters
//   TIMEOUT_CYC   maximum ISSUE cycles before a timeout response
//                 (only used with ARITH_SCHED_TIMEOUT_EN)
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req0_* / req1_*            requester valid/ready, op (0 add, 1 sub,
//                              2 mul, 3 div) and 4-bit operands a, b
//   alu_start                  start level to the datapath (high in ISSUE)
//   alu_in1, alu_in2, alu_sel  latched operands and op select
//   alu_out, alu_err           datapath result, sampled when alu_finish=1
//   alu_finish                 datapath done; ignored outside ISSUE
//   rsp_valid, rsp_ready       response handshake
//   rsp_id                     requester that owns the response
//   rsp_data, rsp_err          captured result
//
// State table
//   state   | meaning
//   IDLE    | arbitrate; grant and latch one request
//   ISSUE   | alu_start high, operands stable, wait for finish (or timeout)
//   RESP    | rsp_valid high, result stable, wait for rsp_ready
// ---------------------------------------------------------------------------
module arith_sched #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,

    output logic       alu_start,
    output logic [3:0] alu_in1,
    output logic [3:0] alu_in2,
    output logic [1:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_err,
    input  logic       alu_finish,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    // r_prio names the requester that wins a tie (0 after reset).
    logic       r_prio;
    logic [3:0] r_in1;
    logic [3:0] r_in2;
    logic [1:0] r_sel;
    logic       r_id;
    logic [7:0] r_data;
    logic       r_err;

    logic       w_idle;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_accept;
    logic       w_tmo;
    logic       w_done;

    if (TIMEOUT_CYC == 0) begin : g_tmo_check
        $error("arith_sched: TIMEOUT_CYC must be at least 1");
    end

    // Grants are gated by rst_n so ready stays low while reset is held,
    // even though the state register already reads IDLE.
    assign w_idle   = rst_n & (r_state == S_IDLE);
    assign w_gnt0   = w_idle & req0_valid & (~req1_valid | ~r_prio);
    assign w_gnt1   = w_idle & req1_valid & (~req0_valid |  r_prio);
    assign w_accept = w_gnt0 | w_gnt1;

`ifdef ARITH_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Loaded with TIMEOUT_CYC-1 on acceptance so that terminal count is
    // reached in the TIMEOUT_CYC-th ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= TMO_LOAD;
        end else if ((r_state == S_ISSUE) && (r_tmo_cnt != '0)) begin
            r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
        end
    end

    assign w_tmo = (r_tmo_cnt == '0);
`else
    assign w_tmo = 1'b0;
`endif

    assign w_done = (r_state == S_ISSUE) & (alu_finish | w_tmo);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_done) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready = w_gnt0;
        req1_ready = w_gnt1;
        alu_start  = (r_state == S_ISSUE);
        rsp_valid  = (r_state == S_RESP);
    end

    // Request latch, arbitration history and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
            r_in1  <= '0;
            r_in2  <= '0;
            r_sel  <= '0;
            r_id   <= 1'b0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                // The loser of this round gets the next tie.
                r_prio <= w_gnt0;
                r_id   <= w_gnt1;
                r_sel  <= w_gnt1 ? req1_op : req0_op;
                r_in1  <= w_gnt1 ? req1_a  : req0_a;
                r_in2  <= w_gnt1 ? req1_b  : req0_b;
            end
            if (w_done) begin
                if (alu_finish) begin
                    r_data <= alu_out;
                    r_err  <= alu_err;
                end else begin
                    r_data <= 8'hFF;
                    r_err  <= 1'b1;
                end
            end
        end
    end

    assign alu_in1  = r_in1;
    assign alu_in2  = r_in2;
    assign alu_sel  = r_sel;
    assign rsp_id   = r_id;
    assign rsp_data = r_data;
    assign rsp_err  = r_err;

endmodule
